// File: rtl/jtag_tap_slave.sv
// Target-side JTAG TAP: oversamples tck/tms/tdi on clk and runs the 1149.1 TAP FSM
// with IR, IDCODE, BYPASS and a 32-bit USER data register toward core logic.
module jtag_tap_slave #(
    parameter int unsigned IR_W        = 4,
    parameter logic [31:0] IDCODE_VAL  = 32'h1789_0001,
    parameter logic [IR_W-1:0] INS_IDCODE = IR_W'(4'h1),
    parameter logic [IR_W-1:0] INS_USER   = IR_W'(4'h8),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tck,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    input  logic [31:0]     user_din,
    output logic [31:0]     user_dout,
    output logic            user_upd,
    output logic [3:0]      tap_state,
    output logic [IR_W-1:0] ir_out
);

    localparam int unsigned DR_W = 32;

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PA_DR, ST_EX2_DR,
        ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PA_IR, ST_EX2_IR, ST_UPD_IR
    } tap_state_e;

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_q;
    logic                   tck_s_c;
    logic                   tms_s_c;
    logic                   tdi_s_c;
    logic                   rise_c;
    logic                   fall_c;

    tap_state_e             state;
    tap_state_e             state_next;

    logic [IR_W-1:0]        ir;
    logic [IR_W-1:0]        ir_sr;
    logic [DR_W-1:0]        dr_sr;
    logic                   bypass_sr;
    logic                   sel_idcode_c;
    logic                   sel_user_c;
    logic                   dr_bit0_c;

    // Pin synchronizers plus one extra tck flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_q    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_q    <= tck_s_c;
        end
    end

    assign tck_s_c = tck_sync[SYNC_STAGES-1];
    assign tms_s_c = tms_sync[SYNC_STAGES-1];
    assign tdi_s_c = tdi_sync[SYNC_STAGES-1];
    assign rise_c  = tck_s_c & ~tck_q;
    assign fall_c  = ~tck_s_c & tck_q;

    // Standard 1149.1 next-state function
    always_comb begin
        state_next = state;
        case (state)
            ST_TLR:    state_next = tms_s_c ? ST_TLR    : ST_RTI;
            ST_RTI:    state_next = tms_s_c ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_next = tms_s_c ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_next = tms_s_c ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_next = tms_s_c ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_next = tms_s_c ? ST_UPD_DR : ST_PA_DR;
            ST_PA_DR:  state_next = tms_s_c ? ST_EX2_DR : ST_PA_DR;
            ST_EX2_DR: state_next = tms_s_c ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_next = tms_s_c ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_next = tms_s_c ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_next = tms_s_c ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_next = tms_s_c ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_next = tms_s_c ? ST_UPD_IR : ST_PA_IR;
            ST_PA_IR:  state_next = tms_s_c ? ST_EX2_IR : ST_PA_IR;
            ST_EX2_IR: state_next = tms_s_c ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_next = tms_s_c ? ST_SEL_DR : ST_RTI;
            default:   state_next = ST_TLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_TLR;
        end else if (rise_c) begin
            state <= state_next;
        end
    end

    assign sel_idcode_c = (ir == INS_IDCODE);
    assign sel_user_c   = (ir == INS_USER);
    assign dr_bit0_c    = (sel_idcode_c || sel_user_c) ? dr_sr[0] : bypass_sr;

    // Register actions on tck rise, keyed on the state being left
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir        <= INS_IDCODE;
            ir_sr     <= '0;
            dr_sr     <= '0;
            bypass_sr <= 1'b0;
            user_dout <= '0;
            user_upd  <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            if (rise_c) begin
                case (state)
                    ST_CAP_IR: ir_sr <= IR_W'(2'b01);
                    ST_SH_IR:  ir_sr <= {tdi_s_c, ir_sr[IR_W-1:1]};
                    ST_UPD_IR: ir    <= ir_sr;
                    ST_CAP_DR: begin
                        if (sel_idcode_c) begin
                            dr_sr <= IDCODE_VAL;
                        end else if (sel_user_c) begin
                            dr_sr <= user_din;
                        end else begin
                            bypass_sr <= 1'b0;
                        end
                    end
                    ST_SH_DR: begin
                        if (sel_idcode_c || sel_user_c) begin
                            dr_sr <= {tdi_s_c, dr_sr[DR_W-1:1]};
                        end else begin
                            bypass_sr <= tdi_s_c;
                        end
                    end
                    ST_UPD_DR: begin
                        if (sel_user_c) begin
                            user_dout <= dr_sr;
                            user_upd  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (state_next == ST_TLR) begin
                    ir <= INS_IDCODE;
                end
            end
        end
    end

    // tdo launched on tck fall so the controller can sample it on its next rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (fall_c) begin
            case (state)
                ST_SH_IR: begin
                    tdo    <= ir_sr[0];
                    tdo_en <= 1'b1;
                end
                ST_SH_DR: begin
                    tdo    <= dr_bit0_c;
                    tdo_en <= 1'b1;
                end
                default: begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end

    assign tap_state = state;
    assign ir_out    = ir;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Drives the TAP like a JTAG controller and compares every step against a
// table-driven behavioural model of the 1149.1 TAP and its registers.
module tb_jtag_tap_slave;

    localparam int unsigned IR_W = 4;

    logic            clk;
    logic            rst;
    logic            tck;
    logic            tms;
    logic            tdi;
    logic            tdo;
    logic            tdo_en;
    logic [31:0]     user_din;
    logic [31:0]     user_dout;
    logic            user_upd;
    logic [3:0]      tap_state;
    logic [IR_W-1:0] ir_out;

    jtag_tap_slave dut (
        .clk       (clk),
        .rst       (rst),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .user_din  (user_din),
        .user_dout (user_dout),
        .user_upd  (user_upd),
        .tap_state (tap_state),
        .ir_out    (ir_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    always @(posedge clk) if (user_upd) upd_cnt <= upd_cnt + 1;

    // Reference TAP: transition tables indexed by state number, tms=0 / tms=1
    int next0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int next1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_state;
    int          m_upd;
    logic [3:0]  m_ir;
    logic [3:0]  m_irsr;
    logic [31:0] m_dr;
    logic [31:0] m_udout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0;
        m_ir    = 4'h1;
        m_irsr  = 4'h0;
        m_dr    = 32'h0;
        m_udout = 32'h0;
    endtask

    function automatic bit m_long_dr();
        return (m_ir == 4'h1) || (m_ir == 4'h8);
    endfunction

    function automatic logic m_exp_tdo();
        if (m_state == 11) return m_irsr[0];
        if (m_state == 4)  return m_dr[0];
        return 1'b0;
    endfunction

    function automatic logic m_exp_en();
        return (m_state == 11) || (m_state == 4);
    endfunction

    task automatic m_rise(input logic t_ms, input logic t_di);
        case (m_state)
            10: m_irsr = 4'd1;
            11: m_irsr = (m_irsr >> 1) | (4'(t_di) << 3);
            15: m_ir   = m_irsr;
            3:  m_dr   = (m_ir == 4'h1) ? 32'h1789_0001 : (m_ir == 4'h8) ? user_din : 32'h0;
            4:  m_dr   = m_long_dr() ? ((m_dr >> 1) | (32'(t_di) << 31)) : 32'(t_di);
            8:  if (m_ir == 4'h8) begin m_udout = m_dr; m_upd++; end
            default: ;
        endcase
        m_state = t_ms ? next1[m_state] : next0[m_state];
        if (m_state == 0) m_ir = 4'h1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tck period: low phase, sample tdo, rising edge, high phase, falling edge
    task automatic jtag_bit(input logic t_ms, input logic t_di, output logic tdo_got);
        tms = t_ms;
        tdi = t_di;
        wait_clk(6);
        check("tdo", 32'(tdo), 32'(m_exp_tdo()));
        check("tdo_en", 32'(tdo_en), 32'(m_exp_en()));
        tdo_got = tdo;
        tck = 1'b1;
        m_rise(t_ms, t_di);
        wait_clk(6);
        check("tap_state", 32'(tap_state), 32'(m_state));
        check("ir_out", 32'(ir_out), 32'(m_ir));
        check("user_dout", user_dout, m_udout);
        check("upd_cnt", 32'(upd_cnt), 32'(m_upd));
        tck = 1'b0;
    endtask

    task automatic step(input logic t_ms);
        logic d;
        jtag_bit(t_ms, 1'b0, d);
    endtask

    // From RTI: load an instruction, return the captured IR bits, end in RTI
    task automatic shift_ir(input logic [3:0] val, output logic [3:0] got);
        logic d;
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < IR_W; i++) begin
            jtag_bit(i == IR_W - 1, val[i], d);
            got[i] = d;
        end
        step(1); step(0);
    endtask

    // From RTI: shift n DR bits, return tdo bits LSB first, end in RTI
    task automatic shift_dr(input logic [31:0] val, input int n, output logic [31:0] got);
        logic d;
        got = '0;
        step(1); step(0); step(0);
        for (int i = 0; i < n; i++) begin
            jtag_bit(i == n - 1, val[i], d);
            got[i] = d;
        end
        step(1); step(0);
    endtask

    initial begin
        logic [31:0] got;
        logic [3:0]  igot;
        logic [7:0]  pat;
        logic        d;
        int          upd0;

        clk = 0; rst = 0; tck = 0; tms = 0; tdi = 0; user_din = 32'h0;
        m_reset();
        m_upd = 0;
        wait_clk(4);
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_ir", 32'(ir_out), 32'h1);
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_user_dout", user_dout, 32'h0);
        check("rst_user_upd", 32'(user_upd), 32'd0);
        rst = 1;
        wait_clk(2);

        // IDCODE readout straight after reset
        step(0);
        shift_dr(32'h0, 32, got);
        check("idcode_seq", got, 32'h1789_0001);

        // BYPASS via all-ones IR: one tck delay, leading 0
        shift_ir(4'hF, igot);
        check("capir_pattern", 32'(igot), 32'h1);
        check("ir_bypass", 32'(ir_out), 32'hF);
        pat = 8'b1011_0010;
        shift_dr({23'b0, 1'b0, pat}, 9, got);
        check("bypass_first", 32'(got[0]), 32'd0);
        check("bypass_pat", 32'(got[8:1]), 32'(pat));

        // USER capture/update
        shift_ir(4'h8, igot);
        check("capir_pattern2", 32'(igot), 32'h1);
        user_din = 32'hDEAD_BEEF;
        upd0 = upd_cnt;
        shift_dr(32'h1234_5678, 32, got);
        check("user_capture", got, 32'hDEAD_BEEF);
        check("user_dout", user_dout, 32'h1234_5678);
        check("user_upd_pulses", 32'(upd_cnt - upd0), 32'd1);

        // Five TMS=1 from mid SH_DR reaches TLR, sixth stays
        step(1); step(0); step(0);
        jtag_bit(1'b0, 1'b1, d);
        jtag_bit(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) step(1);
        check("tlr5_state", 32'(tap_state), 32'd0);
        check("tlr5_ir", 32'(ir_out), 32'h1);
        step(1);
        check("tlr6_state", 32'(tap_state), 32'd0);

        // Async reset mid SH_IR
        step(0);
        step(1); step(1); step(0); step(0);
        jtag_bit(1'b0, 1'b1, d);
        jtag_bit(1'b0, 1'b1, d);
        wait_clk(6);
        check("pre_rst_tdo_en", 32'(tdo_en), 32'd1);
        rst = 0;
        #1;
        check("arst_state", 32'(tap_state), 32'd0);
        check("arst_tdo", 32'(tdo), 32'd0);
        check("arst_tdo_en", 32'(tdo_en), 32'd0);
        check("arst_ir", 32'(ir_out), 32'h1);
        check("arst_user_dout", user_dout, 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1;
        wait_clk(3);

        // Randomized traffic across IDCODE, USER and arbitrary opcodes
        for (int k = 0; k < 16; k++) begin
            logic [3:0] ins;
            for (int i = 0; i < 5; i++) jtag_bit(1'b1, 1'($urandom), d);
            step(0);
            case (k % 3)
                0:       ins = 4'h1;
                1:       ins = 4'h8;
                default: ins = 4'($urandom);
            endcase
            shift_ir(ins, igot);
            check("rand_capir", 32'(igot), 32'h1);
            for (int i = 0; i < 30; i++) begin
                user_din = $urandom;
                jtag_bit($urandom_range(0, 3) == 0, 1'($urandom), d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_slave.md
Name: jtag_tap_slave

Overview:
Target-side JTAG TAP responder: the far end of the on-chip JTAG controller's tck/tms/tdi/tdo link. Used for loopback self-test of the controller and as a debug port into the mips789 core.
- Oversamples tck/tms/tdi on the system clock and runs the IEEE 1149.1 16-state TAP FSM.
- Implements IR, IDCODE, BYPASS and a 32-bit USER data register with parallel capture/update ports toward core logic.

Parameters:
IR_W, 4, instruction register width
IDCODE_VAL, 32'h1789_0001, value captured by IDCODE (bit0 must be 1)
INS_IDCODE, 4'h1, IDCODE opcode (also IR reset value)
INS_USER, 4'h8, USER data register opcode
SYNC_STAGES, 2, synchronizer depth on tck/tms/tdi (fixed 2; parameter documents it)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tck  in  1  JTAG clock from controller, asynchronous to clk
tms  in  1  JTAG mode select, asynchronous
tdi  in  1  JTAG serial data in, asynchronous
tdo  out  1  JTAG serial data out
tdo_en  out  1  high while in Shift-IR/Shift-DR (after falling-edge update)
user_din  in  32  parallel value loaded into USER shift register at Capture-DR
user_dout  out  32  USER register value latched at Update-DR
user_upd  out  1  one-clk pulse when user_dout is written
tap_state  out  4  current TAP state encoding, for debug/flags
ir_out  out  IR_W  current instruction

Behaviour:
- Reset (rst=0, async): state=TEST_LOGIC_RESET, IR=INS_IDCODE, tdo=0, tdo_en=0, user_dout=0, user_upd=0, shift regs=0, synchronizer flops=0.
- tck, tms, tdi each pass through 2 clk flops. tck_q is a third flop; rise = sync & ~tck_q, fall = ~sync & tck_q.
- Rising-edge detection latency: 3 clk after pin edge. tck high and low phases must each be >=4 clk; shorter pulses are undefined.
- State encoding 0..15: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- FSM advances only on rise, using synchronized tms, per standard 1149.1 transitions. TMS=1 on 5 consecutive rises reaches TLR from any state.
- Entering TLR forces IR=INS_IDCODE.
- Rise actions, keyed on the state before the transition:
  - CAP_IR: ir_sr<={0..,2'b01}.
  - SH_IR: ir_sr<={tdi,ir_sr[IR_W-1:1]} (LSB first).
  - UPD_IR: IR<=ir_sr.
  - CAP_DR: selected DR loads IDCODE_VAL (IDCODE), user_din (USER), or 0 (BYPASS).
  - SH_DR: selected DR shifts right with tdi into MSB. BYPASS is 1 bit.
  - UPD_DR with IR==INS_USER: user_dout<=user_sr, user_upd=1 for exactly one clk.
- Decode: IR==INS_IDCODE selects IDCODE; IR==INS_USER selects USER; every other opcode, including all-ones, selects BYPASS.
- tdo updates only on fall:
  - In SH_IR: tdo=ir_sr[0], tdo_en=1.
  - In SH_DR: tdo=selected DR bit0, tdo_en=1.
  - Otherwise: tdo=0, tdo_en=0.
  - The controller samples tdo on its next rising tck.
- Simultaneous rise and fall cannot occur (single synchronized signal).
- rst asserted mid-shift: immediate return to TLR, IR=IDCODE, partial shift discarded, user_dout unchanged from its reset value 0.
- user_din is sampled only on the CAP_DR rise clk; it is not otherwise registered.

Test Plan:
- Release rst, TMS=0 one tck then path to SH_DR, shift 32 bits with tdi=0 -> tdo sequence LSB first equals 32'h1789_0001, tdo_en high during shift only.
- Load IR=4'hF (BYPASS), shift DR pattern 8'b1011_0010 -> tdo returns same pattern delayed by exactly one tck; first bit 0.
- IR=4'h8, user_din=32'hDEAD_BEEF; Capture/shift-in 32'h1234_5678 -> tdo yields DEAD_BEEF LSB first; after UPD_DR, user_dout=32'h1234_5678 with a single-clk user_upd.
- Capture-IR then shift 4 bits -> tdo emits 1,0,0,0 (2'b01 capture pattern LSB first); ir_out unchanged until UPD_IR.
- From SH_DR mid-shift, TMS=1 for 5 tck -> tap_state=0 (TLR), ir_out=4'h1; a 6th TMS=1 keeps TLR.
- Assert rst for 1 clk mid SH_IR -> tap_state=0, tdo=0, tdo_en=0, ir_out=4'h1 asynchronously; tck pulses of 2-clk width are not required to be tracked (excluded from check).
